shift_sequencer: RTL and testbench
==================================

# shift_sequencer

- **Role:** upstream control stage for the 8-bit left/right shift register.
- **Input side:** accepts a job over a valid/ready handshake. A job is a byte, a direction and a shift count.
- **Register control:** drives the register's active-low parallel-load strobe, direction select and parallel data to load the byte and then shift it the requested number of times.
- **Output side:** captures the register's output at the exact cycle the shifting completes and presents it on a valid/ready output port.
- **Why sampling timing matters:** the register has no hold mode and shifts on every clock that does not load. The sequencer therefore owns all timing of when the result is sampled.

## Interface
Parameters:
- `WIDTH`, default 8: data width; must match the shift register.
- `CNT_W`, default 4: width of the shift-count field.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: job offered.
- `in_ready` output 1: sequencer can accept a job.
- `in_data` input WIDTH: byte to load.
- `in_dir` input 1: 0 = shift left, 1 = shift right. Same encoding as the register's `left_right_shift`.
- `in_count` input CNT_W: number of shift cycles, 0..15.
- `sr_load_enable` output 1: connects to the register's `load_enable`. 0 = load, 1 = shift.
- `sr_left_right_shift` output 1: connects to the register's `left_right_shift`.
- `sr_i` output WIDTH: connects to the register's `i`.
- `sr_q` input WIDTH: connects to the register's `q`.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output WIDTH: shifted result.

## Operation
**States and transitions:**
- `IDLE` → `LOAD` on `in_valid && in_ready`.
- `LOAD` → `CAPT` if the latched count is 0; otherwise `LOAD` → `SHIFT`.
- `SHIFT` → `CAPT` when the remaining count reaches 1.
- `CAPT` → `DONE` always.
- `DONE` → `IDLE` on `out_ready`.

**Job acceptance:**
- `in_ready` = 1 only in `IDLE`.
- On accept, latch `in_data` into `data_r`, `in_dir` into `dir_r`, and `in_count` into `cnt_r`.

**Register control (Moore decode from state):**
- `sr_load_enable` = 0 in every state except `SHIFT`, where it is 1.
- `sr_i` = `data_r` at all times.
- `sr_left_right_shift` = `dir_r` at all times.
- Effect: in `IDLE`, `LOAD`, `CAPT` and `DONE` the register continuously reloads `data_r`, which keeps it deterministic.

**Counting and capture:**
- `SHIFT`: decrement `cnt_r` every cycle.
- `CAPT`: the register holds the final value. At the end of `CAPT`, `out_data` <= `sr_q` and `out_valid` <= 1.

**Output handshake:**
- `DONE`: hold `out_valid` and `out_data` stable until `out_ready`.
- On that edge, `out_valid` <= 0 and the state returns to `IDLE`.
- `out_data` keeps its last value.

**Arithmetic:**
- Shifts fill with zeros.
- Counts of 8..15 yield 0x00; the register performs every requested shift.

**Reset mid-operation:**
- Any state returns to `IDLE` immediately.
- Reset values: `out_valid` = 0, `out_data` = 0, `data_r` = 0, `dir_r` = 0, `cnt_r` = 0.
- Resulting output values: `in_ready` = 1, `sr_load_enable` = 0, `sr_i` = 0, `sr_left_right_shift` = 0.

## Timing
- Accept edge E0; the register loads at E1.
- Shifts occur at E2..E(1+N).
- `out_data` is captured at E(2+N), and `out_valid` is high from E(2+N).
- Latency from accept to `out_valid`: N+2 cycles. For N = 0 it is 2 cycles.
- Throughput: one job per N+4 cycles when `out_ready` is held high. This covers `LOAD`, N `SHIFT` cycles, `CAPT`, one `DONE` cycle and one `IDLE` accept cycle.
- `in_ready` falls the cycle after accept.
- `in_valid` asserted during `DONE` is not accepted until the cycle after `out_ready` is seen.

## Configuration
Macro: `SHIFT_SEQ_CLAMP_EN`.
- **Defined:** the count is clamped to min(`in_count`, `WIDTH`) at accept. Counts ≥ `WIDTH` take `WIDTH` shift cycles. The result is identical (0x00) and latency is reduced.
- **Undefined:** the full count is executed; latency is `in_count` + 2.

## Test plan
- Reset while in `SHIFT` with `in_count` = 5 → next cycle `in_ready` = 1, `out_valid` = 0, `sr_load_enable` = 0, `sr_i` = 0x00.
- `in_data` = 0x96, `dir` = 0 (left), `count` = 3 → `out_data` = 0xB0, `out_valid` rises exactly 5 cycles after accept.
- `in_data` = 0x96, `dir` = 1 (right), `count` = 0 → `out_data` = 0x96 after 2 cycles. `sr_load_enable` is never 1 during the job.
- `in_data` = 0xFF, `dir` = 1, `count` = 12 → `out_data` = 0x00.
  - Latency 14 without `SHIFT_SEQ_CLAMP_EN`.
  - Latency 10 with it.
- Backpressure: `out_ready` held low 4 cycles with `in_valid` high throughout.
  - `out_valid` and `out_data` stay stable.
  - `in_ready` stays 0 until the cycle after `out_ready`.
  - The next job is accepted in `IDLE` one cycle after the result handshake.
- Back-to-back jobs 0x01 left 7 and 0x80 right 7, with `out_ready` = 1 → results 0x80 then 0x01, each 9 cycles after its own accept.

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Control stage for an external 8-bit left/right shift register.
//               Accepts a job (byte, direction, count), loads the register,
//               lets it shift the requested number of cycles, then captures
//               the register output and offers it on a valid/ready port.
//               Optional macro SHIFT_SEQ_CLAMP_EN clamps the shift count to
//               WIDTH at accept (same result, shorter latency).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  output logic             sr_load_enable,
  output logic             sr_left_right_shift,
  output logic [WIDTH-1:0] sr_i,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE_CNT = CNT_W'(1);
`ifdef SHIFT_SEQ_CLAMP_EN
  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(WIDTH);
`endif

  state_t           state;
  logic [WIDTH-1:0] data_r;
  logic             dir_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] w_accept_cnt;

  // Count latched at accept; optionally clamped since shifts past WIDTH only add zeros
`ifdef SHIFT_SEQ_CLAMP_EN
  assign w_accept_cnt = (in_count > C_MAX_CNT) ? C_MAX_CNT : in_count;
`else
  assign w_accept_cnt = in_count;
`endif

  // Moore decode: the register reloads data_r in every state but SHIFT
  assign in_ready            = (state == IDLE);
  assign sr_load_enable      = (state == SHIFT);
  assign sr_i                = data_r;
  assign sr_left_right_shift = dir_r;

  // Sequencer FSM: job latch, shift counting, result capture and output handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      data_r    <= '0;
      dir_r     <= 1'b0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            dir_r  <= in_dir;
            cnt_r  <= w_accept_cnt;
            state  <= LOAD;
          end
        end
        LOAD: begin
          // Register loads data_r on this edge; zero-count jobs skip shifting
          if (cnt_r == '0) state <= CAPT;
          else             state <= SHIFT;
        end
        SHIFT: begin
          cnt_r <= cnt_r - C_ONE_CNT;
          if (cnt_r == C_ONE_CNT) state <= CAPT;
        end
        CAPT: begin
          // Register output holds the final shifted value during this cycle
          out_data  <= sr_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed self-checking bench for shift_sequencer, including a
//               behavioural model of the external 8-bit shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_dir = 1'b0;
  logic [3:0] in_count = 4'd0;
  logic       sr_load_enable;
  logic       sr_left_right_shift;
  logic [7:0] sr_i;
  logic [7:0] sr_q;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  int total = 0;
  int passed = 0;
  logic       sle_seen;
  logic [7:0] held;

  shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .in_dir              (in_dir),
    .in_count            (in_count),
    .sr_load_enable      (sr_load_enable),
    .sr_left_right_shift (sr_left_right_shift),
    .sr_i                (sr_i),
    .sr_q                (sr_q),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data)
  );

  always #5 clk = ~clk;

  // Model of the shift register: no hold mode, zero fill
  always @(posedge clk) begin
    if (!sr_load_enable)          sr_q <= sr_i;
    else if (sr_left_right_shift) sr_q <= sr_q >> 1;
    else                          sr_q <= sr_q << 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called just after the accept edge; waits for out_valid and checks latency and data
  task automatic wait_result(input string tag, input logic [7:0] exp_data, input int exp_lat);
    int k;
    sle_seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      sle_seen = sle_seen | sr_load_enable;
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_data"}, {24'h0, out_data}, {24'h0, exp_data});
  endtask

  // Offers one job, returns just after the accept edge
  task automatic offer(input string tag, input logic [7:0] d, input logic dir, input logic [3:0] n);
    @(negedge clk);
    in_data = d; in_dir = dir; in_count = n; in_valid = 1'b1;
    chk({tag, "_in_ready_before"}, in_ready, 1);
    @(posedge clk); #1;
    chk({tag, "_in_ready_after"}, in_ready, 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sle", sr_load_enable, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk); reset = 1'b1;

    // Reset in the middle of SHIFT
    offer("mid", 8'h5A, 1'b0, 4'd5);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_in_shift", sr_load_enable, 1);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sle", sr_load_enable, 0);
    chk("mid_rst_sr_i", sr_i, 8'h00);
    chk("mid_rst_dir", sr_left_right_shift, 0);
    reset = 1'b1;

    // 0x96 left 3 -> 0xB0 after 5
    offer("l3", 8'h96, 1'b0, 4'd3);
    in_valid = 1'b0;
    wait_result("l3", 8'hB0, 5);
    @(posedge clk); #1;
    chk("l3_valid_drop", out_valid, 0);
    chk("l3_data_kept", out_data, 8'hB0);

    // 0x96 right 0 -> 0x96 after 2, never shifting
    offer("r0", 8'h96, 1'b1, 4'd0);
    in_valid = 1'b0;
    wait_result("r0", 8'h96, 2);
    chk("r0_no_shift", sle_seen, 0);
    @(posedge clk); #1;

    // 0xFF right 12 -> 0x00
    offer("r12", 8'hFF, 1'b1, 4'd12);
    in_valid = 1'b0;
`ifdef SHIFT_SEQ_CLAMP_EN
    wait_result("r12", 8'h00, 10);
`else
    wait_result("r12", 8'h00, 14);
`endif
    @(posedge clk); #1;

    // 0x0F right 15 -> 0x00
    offer("r15", 8'h0F, 1'b1, 4'd15);
    in_valid = 1'b0;
`ifdef SHIFT_SEQ_CLAMP_EN
    wait_result("r15", 8'h00, 10);
`else
    wait_result("r15", 8'h00, 17);
`endif
    @(posedge clk); #1;

    // Backpressure: 0x3C right 2 -> 0x0F held, next job 0xA5 left 1 waits
    out_ready = 1'b0;
    offer("bp", 8'h3C, 1'b1, 4'd2);
    in_data = 8'hA5; in_dir = 1'b0; in_count = 4'd1;
    wait_result("bp", 8'h0F, 4);
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_next_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_result("bp_next", 8'h4A, 3);
    @(posedge clk); #1;

    // Back-to-back: 0x01 left 7 then 0x80 right 7, each 9 cycles after accept
    offer("b2b1", 8'h01, 1'b0, 4'd7);
    in_data = 8'h80; in_dir = 1'b1; in_count = 4'd7;
    wait_result("b2b1", 8'h80, 9);
    @(posedge clk); #1;
    chk("b2b_idle", in_ready, 1);
    @(posedge clk); #1;
    chk("b2b2_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_result("b2b2", 8'h01, 9);
    @(posedge clk); #1;
    chk("b2b2_valid_drop", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
